uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Two-requester UART transmit scheduler. It round-robin arbitrates byte requests from two independent producers and generates its own runtime-selectable bit timing from the 24 MHz system clock. It serialises the granted byte as an 8N1 frame on one shared TX line. It sits between on-chip byte sources (e.g. status reporter and debug console) and the board's UART TX pin.

## Interface

Parameters:
- DIV0, 20000, clki cycles per bit for baud_sel=0 (1200 Bd)
- DIV1, 2500, cycles per bit for baud_sel=1 (9600 Bd)
- DIV2, 417, cycles per bit for baud_sel=2 (57600 Bd)
- DIV3, 208, cycles per bit for baud_sel=3 (115200 Bd)

Ports:
- clki  in  1  system clock, 24 MHz
- rstn  in  1  reset, asynchronous, active-low
- baud_sel  in  2  bit-rate select, sampled at byte acceptance
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte, held stable while req0_valid=1 and not accepted
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1
- tx  out  1  serial output, idle high
- busy  out  1  frame in progress
- grant_id  out  1  requester owning current or most recent frame

## Operation

- States: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- IDLE arbitration, combinational on registered last_grant:
  - only one valid: that requester wins;
  - both valid: the requester != last_grant wins.
- reqN_ready = (state==IDLE) & winner==N & reqN_valid. Transfer occurs on a clki edge with valid&ready. At most one ready is high per cycle.
- On transfer, registered in the same edge:
  - shift_reg <= data; div_sel <= baud_sel; grant_id, last_grant <= N;
  - bit_cnt <= 0; div_cnt <= 0; state <= START; busy <= 1.
- Bit timer: 16-bit div_cnt increments every cycle outside IDLE. Tick when div_cnt == DIV[div_sel]-1, then div_cnt <= 0. All DIV values must be ≥2 and ≤65535.
- START: tx=0. On tick, go to DATA.
- DATA: tx=shift_reg[0], LSB first. On tick, shift right, bit_cnt++. After the 8th tick (bit_cnt==7 at tick), go to STOP.
- STOP: tx=1. On tick, go to IDLE and set busy <= 0.
- tx is a registered output, glitch-free.
- A baud_sel change mid-frame has no effect until the next acceptance.
- Valid deasserted before acceptance is legal. The request is simply not served.

## Timing

- Reset, asynchronous assertion:
  - outputs: tx=1, busy=0, grant_id=0;
  - internal: state=IDLE, last_grant=1 (req0 wins the first tie), counters=0;
  - req0_ready and req1_ready are 0 while rstn=0.
- Reset mid-frame: frame aborted, tx high immediately. Accepted byte is lost and not re-requested.
- Latency: tx falls on the first edge after the acceptance edge.
- Bit timing: each bit lasts exactly DIV[div_sel] cycles. Frame is 10·DIV cycles from tx fall to return to IDLE.
- Back-to-back: ready is asserted in the first IDLE cycle. Frame-to-frame period is 10·DIV+1 cycles, so the stop bit is effectively DIV+1 cycles.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1…

## Configuration

- UART_ARB_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP, lasting one DIV period;
  - tx = even parity (XOR of the 8 data bits);
  - frame is 11·DIV cycles; back-to-back period is 11·DIV+1.
- UART_ARB_PARITY_EN undefined: no PARITY state, plain 8N1 as above.

## Test plan

- baud_sel=3, req0 sends 0x55 after reset → req0_ready pulses 1 cycle. tx low 208 cycles, then 1,0,1,0,1,0,1,0 at 208 cycles each, then high. busy falls 2080 cycles after tx fall.
- Both valid in the same cycle after reset, req0=0xA1, req1=0x3C → 0xA1 sent first with grant_id=0, then 0x3C with grant_id=1. Second tx fall occurs 2081 cycles after the first.
- Both held valid for 4 frames → grant_id sequence 0,1,0,1. Never two readies in one cycle.
- baud_sel=1 at acceptance, switched to 3 mid-frame → all bits 2500 cycles. Next frame uses 208.
- rstn pulsed low during DATA bit 3 → tx=1 and busy=0 immediately. After release, a req1-only request is accepted. On a later tie, req0 wins.
- With UART_ARB_PARITY_EN, send 0x07 at baud_sel=3 → parity bit 1 after bit 7. Frame is 2288 cycles.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin scheduler for two byte producers sharing one UART TX line.
//   The granted byte goes out as an 8N1 frame: start bit, eight data bits
//   LSB first, then a stop bit. Bit timing comes from an internal divider.
//   Four divider values are chosen by baud_sel, which is sampled when a
//   byte is accepted.
//
//   Optional feature: define UART_ARB_PARITY_EN to add an even-parity bit
//   between the last data bit and the stop bit.
//
// Ports
//   clki        system clock
//   rstn        asynchronous, active-low reset
//   baud_sel    bit-rate select (0..3 -> DIV0..DIV3 clocks per bit)
//   reqN_valid  requester N offers reqN_data
//   reqN_data   byte from requester N, held while valid and not yet accepted
//   reqN_ready  byte from requester N accepted on this clock edge
//   tx          registered serial output, idle high
//   busy        frame in progress
//   grant_id    requester owning the current or most recent frame
module uart_tx_arb #(
  parameter int unsigned DIV0 = 20000,
  parameter int unsigned DIV1 = 2500,
  parameter int unsigned DIV2 = 417,
  parameter int unsigned DIV3 = 208
) (
  input  logic       clki,
  input  logic       rstn,
  input  logic [1:0] baud_sel,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [1:0]  div_sel_q, div_sel_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
`ifdef UART_ARB_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        winner;
  logic        xfer;
  logic [7:0]  win_data;
  logic [15:0] div_val;
  logic        tick;

  // State register
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      div_cnt_q    <= 16'd0;
      div_sel_q    <= 2'd0;
      last_grant_q <= 1'b1;    // requester 0 wins the first tie
      grant_id_q   <= 1'b0;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
`ifdef UART_ARB_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      div_sel_q    <= div_sel_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      tx_q         <= tx_d;
`ifdef UART_ARB_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    div_sel_d    = div_sel_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
`ifdef UART_ARB_PARITY_EN
    parity_d     = parity_q;
`endif

    xfer     = req0_ready | req1_ready;
    win_data = req1_ready ? req1_data : req0_data;

    case (div_sel_q)
      2'd0:    div_val = 16'(DIV0);
      2'd1:    div_val = 16'(DIV1);
      2'd2:    div_val = 16'(DIV2);
      default: div_val = 16'(DIV3);
    endcase

    tick = (div_cnt_q == div_val - 16'd1);

    if (state_q != ST_IDLE) begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // busy drops in the first idle cycle, unless the next byte is
        // accepted right away, so back-to-back frames keep it high.
        busy_d = xfer;
        if (xfer) begin
          shift_d      = win_data;
          div_sel_d    = baud_sel;
          grant_id_d   = req1_ready;
          last_grant_d = req1_ready;
          bit_cnt_d    = 3'd0;
          div_cnt_d    = 16'd0;
          state_d      = ST_START;
`ifdef UART_ARB_PARITY_EN
          // Computed before shifting destroys the byte
          parity_d     = ^win_data;
`endif
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: arbitration and the next tx level
  always_comb begin
    // On a tie the requester that was not served last wins
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else                          winner = req1_valid;

    req0_ready = rstn && (state_q == ST_IDLE) && req0_valid && !winner;
    req1_ready = rstn && (state_q == ST_IDLE) && req1_valid &&  winner;

    // tx follows the state one cycle late, so the start bit begins on the
    // edge after acceptance and every bit still lasts one full divider period.
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int unsigned D0 = 16;
  localparam int unsigned D1 = 50;
  localparam int unsigned D2 = 2;
  localparam int unsigned D3 = 208;
`ifdef UART_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] baud_sel;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx, busy, grant_id;

  always #5 clk = ~clk;

  uart_tx_arb #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
    .clki      (clk),
    .rstn      (rstn),
    .baud_sel  (baud_sel),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct {
    bit         gid;
    logic [7:0] data;
    int         div;
    bit         b2b;   // frame must start exactly one idle cycle after the previous one
  } exp_t;

  exp_t       sb[$];
  logic [7:0] dl0[$];
  logic [7:0] dl1[$];
  int         checks = 0;
  int         errors = 0;
  bit         model_last = 1'b1;

  // Monitor state
  bit          in_frame  = 1'b0;
  bit          chk_after = 1'b0;
  bit          skip_low  = 1'b0;
  int          cnt, cyc = 0, prev_start = 0, prev_len = 0, nframes = 0;
  int          werr, berr, gerr, dual = 0;
  exp_t        cur;
  bit [NB-1:0] bits;

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  // Line levels of a whole frame, one entry per bit period
  function automatic bit [NB-1:0] frame_bits(input logic [7:0] d);
    bit [NB-1:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
`ifdef UART_ARB_PARITY_EN
    b[9] = ^d;
`endif
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  // Monitor: decodes every tx frame cycle by cycle and checks it against the
  // head of the scoreboard.
  initial begin : monitor
    bit exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (req0_ready && req1_ready) dual++;
      if (!rstn) begin
        in_frame  = 1'b0;
        chk_after = 1'b0;
        skip_low  = 1'b0;
        continue;
      end
      if (chk_after) begin
        chk_after = 1'b0;
        exp_b = (sb.size() > 0) && sb[0].b2b;
        checks++;
        if (busy !== exp_b) begin
          errors++;
          $display("FAIL busy_after_frame: got %b want %b", busy, exp_b);
        end
      end
      if (skip_low) begin
        if (tx === 1'b1) skip_low = 1'b0;
      end else if (!in_frame && tx === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: tx fell at cycle %0d with nothing expected", cyc);
          skip_low = 1'b1;
        end else begin
          cur = sb.pop_front();
          if (cur.b2b) begin
            checks++;
            if (cyc - prev_start != prev_len + 1) begin
              errors++;
              $display("FAIL b2b_period: got %0d cycles want %0d", cyc - prev_start, prev_len + 1);
            end
          end
          bits       = frame_bits(cur.data);
          in_frame   = 1'b1;
          cnt        = 0;
          werr       = 0;
          berr       = 0;
          gerr       = 0;
          prev_start = cyc;
          prev_len   = NB * cur.div;
        end
      end
      if (in_frame) begin
        if (tx !== bits[cnt / cur.div]) werr++;
        if (busy !== 1'b1) berr++;
        if (grant_id !== cur.gid) gerr++;
        cnt++;
        if (cnt == NB * cur.div) begin
          in_frame  = 1'b0;
          chk_after = 1'b1;
          nframes++;
          checks += 3;
          if (werr != 0) begin
            errors++;
            $display("FAIL frame_wave: got %0d wrong tx samples want 0 (data 0x%02h div %0d)", werr, cur.data, cur.div);
          end
          if (gerr != 0) begin
            errors++;
            $display("FAIL frame_grant: got %0d cycles grant_id!=%0d want 0", gerr, cur.gid);
          end
          if (berr != 0) begin
            errors++;
            $display("FAIL frame_busy: got %0d cycles busy low want 0", berr);
          end
          $display("frame %0d: gid=%0d data=0x%02h div=%0d b2b=%0d", nframes, cur.gid, cur.data, cur.div, cur.b2b);
        end
      end
    end
  end

  // Issue one request pattern. The model predicts the grant order from the
  // round-robin rule, then the driver holds the valids until nfr bytes have
  // been accepted in total.
  task automatic issue(input bit v0, input bit v1, input logic [1:0] sel, input int nfr);
    int m0 = 0, m1 = 0, i0 = 0, i1 = 0, acc = 0, guard = 0;
    bit w, h0, h1;
    exp_t e;
    for (int k = 0; k < nfr; k++) begin
      if (v0 && v1) w = ~model_last;
      else          w = v1;
      e.gid = w;
      if (w) begin e.data = dl1[m1]; m1++; end
      else   begin e.data = dl0[m0]; m0++; end
      e.div = div_of(sel);
      e.b2b = (k > 0);
      model_last = w;
      sb.push_back(e);
    end
    @(negedge clk);
    baud_sel   = sel;
    req0_valid = v0;
    req1_valid = v1;
    if (v0) req0_data = dl0[0];
    if (v1) req1_data = dl1[0];
    while (acc < nfr && guard < 40000) begin
      #1;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(negedge clk);
      guard++;
      if (h0 || h1) begin
        chk("ready_after_accept", {req0_ready, req1_ready}, 2'b00);
        if (h0) begin acc++; i0++; if (i0 < dl0.size()) req0_data = dl0[i0]; end
        if (h1) begin acc++; i1++; if (i1 < dl1.size()) req1_data = dl1[i1]; end
      end
    end
    if (acc < nfr) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d accepts want %0d", acc, nfr);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || in_frame || chk_after) && g < 40000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d frames pending want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must go to their idle values at once
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn       = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    sb.delete();
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rstn       = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic void fill(input int n0, input int n1);
    dl0.delete();
    dl1.delete();
    for (int i = 0; i < n0; i++) dl0.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n1; i++) dl1.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin : stim
    int g;
    rstn       = 1'b0;
    baud_sel   = 2'd0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    do_reset();

    // Single byte 0x55 from requester 0 at the fastest rate
    dl0.delete(); dl1.delete();
    dl0.push_back(8'h55);
    issue(1'b1, 1'b0, 2'd3, 1);
    wait_idle();

    // Tie straight after reset: requester 0 first, then 1, back to back
    do_reset();
    dl0.delete(); dl1.delete();
    dl0.push_back(8'hA1);
    dl1.push_back(8'h3C);
    issue(1'b1, 1'b1, 2'd3, 2);
    wait_idle();

    // Both held valid for four frames: grants alternate
    fill(2, 2);
    issue(1'b1, 1'b1, 2'd3, 4);
    wait_idle();

    // baud_sel changed mid-frame must not affect the frame in flight
    fill(1, 1);
    issue(1'b1, 1'b0, 2'd1, 1);
    baud_sel = 2'd3;
    wait_idle();
    issue(1'b0, 1'b1, 2'd3, 1);
    wait_idle();

    // Reset during data bit 3 of a requester-1 frame
    fill(1, 1);
    issue(1'b0, 1'b1, 2'd3, 1);
    g = 0;
    while (tx !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (4 * D3 + 100) @(negedge clk);
    do_reset();
    fill(1, 1);
    issue(1'b0, 1'b1, 2'd0, 1);
    wait_idle();
    fill(1, 1);
    issue(1'b1, 1'b1, 2'd0, 2);
    wait_idle();

    // Randomised rounds over the faster rates, including the 2-cycle divider
    for (int r = 0; r < 30; r++) begin
      int mode, n;
      logic [1:0] sel;
      mode = $urandom_range(1, 3);
      sel  = 2'($urandom_range(0, 2));
      n    = (mode == 3) ? $urandom_range(2, 4) : $urandom_range(1, 2);
      fill(n, n);
      issue(mode[0], mode[1], sel, n);
      wait_idle();
    end

    chk("dual_ready_cycles", dual, 0);
    chk("frames_seen", nframes, nframes == 0 ? 1 : nframes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
